proc_control: RTL
=================

# proc_control

Control unit of the synchronous-execution processor: the consumer end of the 2-bit step counter. It latches an instruction word on `Run`, decodes the current step `Tstep` and drives the bus/register enables for that step. It also drives the counter's clear input so every instruction starts at T0 and the counter parks at T0 while idle. It sits between the instruction source (DIN), the step counter, and the register file/ALU datapath.

## Interface
- No parameters. The instruction format is fixed at 9 bits: `III XXX YYY`, where III is the opcode, XXX the destination/first register and YYY the source register.
- `Clock`  in  1  — single system clock; all state changes on posedge.
- `Clear`  in  1  — synchronous, active-high reset.
- `Run`  in  1  — start request, sampled only at T0.
- `DIN`  in  9  — instruction word at T0; immediate data word at T1 for mvi.
- `Tstep`  in  2  — current step from the step counter.
- `StepClear`  out  1  — drives the step counter's clear input.
- `IRin`  out  1  — instruction latch strobe (also exported for datapath debug).
- `Rin`  out  8  — one-hot register write enables.
- `Rout`  out  8  — one-hot register bus-drive enables.
- `Ain`, `Gin`, `Gout`, `DINout`  out  1 each — ALU input latch, ALU result latch, G to bus, DIN to bus.
- `AddSub`  out  1  — 0 = add, 1 = subtract.
- `Done`  out  1  — last step of the current instruction.
- `Illegal`  out  1  — sticky flag set by an undefined opcode.

## Operation
- **State.**
  - `IR[8:0]` — reset 0.
  - `Busy` — reset 0.
  - `Illegal` — reset 0.
  - All other outputs are combinational in `Tstep`, `IR`, `Busy`, `Run` and `Clear`. While `Clear`=1, every control output except `StepClear` is 0, and `StepClear`=1.
- **T0, idle.**
  - If `Run`=0: `StepClear`=1 and the counter holds at 0.
  - If `Run`=1: `IRin`=1, `IR` is loaded from `DIN`, and `Busy` is set at the edge.
- **Opcode 000, mv Rx,Ry.** T1: `Rout[Y]`, `Rin[X]`, `Done`.
- **Opcode 001, mvi Rx,#D.** T1: `DINout`, `Rin[X]`, `Done`.
- **Opcode 010, add.**
  - T1: `Rout[X]`, `Ain`.
  - T2: `Rout[Y]`, `Gin`, `AddSub`=0.
  - T3: `Gout`, `Rin[X]`, `Done`.
- **Opcode 011, sub.** Same as add, with `AddSub`=1 at T2.
- **Opcodes 1xx.**
  - T1: `Done` only; no `Rin`/`Rout`.
  - `Illegal` is set at that edge and held until `Clear`.
- **StepClear** = `Clear` | `Done` | (T0 & !`Run`). `Busy` clears on the edge where `Done`=1.
- **Run while Busy.** Ignored. `IR` loads only at T0.
- **Back-to-back instructions.** `Run` held high gives a new fetch in the cycle right after `Done`, with no idle cycle.
- **Defensive T0.** `Tstep`=0 with `Busy`=1 cannot happen in correct operation. If it does, the block treats it as T0 and may fetch.
- **Illegal step combinations** (e.g. T2 on mv, or `Tstep`≠0 with `Busy`=0): all enables are 0 and `StepClear`=1, which forces recovery to T0.

## Timing
- **Cycles per instruction:** mv/mvi/illegal 2 (T0, T1); add/sub 4 (T0–T3).
- **Done** is high for exactly one cycle, in the instruction's final step. The counter reads 0 on the following cycle.
- **Register writes** happen at the posedge ending the step in which `Rin` is asserted.
- **Clear mid-instruction:**
  - Next cycle: `Tstep`=0, `IR`=0, `Busy`=0, `Illegal`=0.
  - No enables are asserted in the Clear cycle. A partially executed add leaves the A/G registers stale but writes no Rx.

## Structure
- **Shared package `proc_pkg`:**
  - opcode constants: `OP_MV`=3'b000, `OP_MVI`=3'b001, `OP_ADD`=3'b010, `OP_SUB`=3'b011;
  - step constants `T0`..`T3`;
  - IR field index constants.
- **One sub-module, `dec3to8`:** 3-bit to one-hot 8 decoder with an enable. Instantiated twice, once for the X field and once for the Y field.

## Test plan
- **Idle park:** Clear for 2 cycles, then `Run`=0 for 5 cycles → `StepClear`=1 every cycle, `Tstep` stays 0, all enables 0.
- **mvi R3,#0x05:** `DIN`=9'b001_011_000 with `Run` at T0, then `DIN`=5 at T1 → T1 shows `DINout`=1, `Rin`=8'h08, `Done`=1; `Tstep`=0 the next cycle.
- **add R1,R2:** `DIN`=9'b010_001_010 →
  - T1: `Rout`=8'h02, `Ain`;
  - T2: `Rout`=8'h04, `Gin`, `AddSub`=0;
  - T3: `Gout`, `Rin`=8'h02, `Done`.
  - Repeat with sub 011 → `AddSub`=1 at T2.
- **Back-to-back:** `Run` held high with mv R0,R7 then mv R7,R0 → `Done` in cycles 2 and 4, `IRin` in cycles 1 and 3, no idle cycle between.
- **Illegal:** `DIN`=9'b111_000_000 → `Done` at T1, no `Rin`/`Rout`, `Illegal`=1 and held through a following valid mv, cleared only by `Clear`.
- **Clear at T2 of an add** → no `Rin` asserted; next cycle `Tstep`=0 and `IR`=0; a new mv then executes normally.

Source files
------------

// File: rtl/proc_pkg.sv
// proc_pkg: opcode, step and instruction-field constants shared by the control unit
package proc_pkg;
  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;
  localparam int IR_OP = 6;
  localparam int IR_X  = 3;
  localparam int IR_Y  = 0;
endpackage

// File: rtl/dec3to8.sv
// dec3to8: 3-bit index w to one-hot y, all zero when en is low
module dec3to8 (
  input  logic [2:0] w,
  input  logic       en,
  output logic [7:0] y
);
  assign y = en ? 8'(1) << w : '0;
endmodule

// File: rtl/proc_control.sv
// proc_control: latches IR on Run at T0, decodes Tstep into Rin/Rout/Ain/Gin/Gout/DINout/AddSub/Done, drives StepClear, sticky Illegal
module proc_control
  import proc_pkg::*;
(
  input  logic       Clock,
  input  logic       Clear,
  input  logic       Run,
  input  logic [8:0] DIN,
  input  logic [1:0] Tstep,
  output logic       StepClear,
  output logic       IRin,
  output logic [7:0] Rin,
  output logic [7:0] Rout,
  output logic       Ain,
  output logic       Gin,
  output logic       Gout,
  output logic       DINout,
  output logic       AddSub,
  output logic       Done,
  output logic       Illegal
);
  logic [8:0] ir;
  logic       busy, ill;
  logic [2:0] op;
  logic [7:0] rx, ry;
  logic       t0, t1, t2, t3, fetch, exec, mvs, ar, valid;
  assign op = ir[IR_OP +: 3];
  dec3to8 u_x (.w(ir[IR_X +: 3]), .en(1'b1), .y(rx));
  dec3to8 u_y (.w(ir[IR_Y +: 3]), .en(1'b1), .y(ry));
  always_comb begin
    t0        = Tstep == T0;
    t1        = Tstep == T1;
    t2        = Tstep == T2;
    t3        = Tstep == T3;
    fetch     = !Clear && t0 && Run;
    exec      = !Clear && busy && !t0;
    mvs       = exec && t1 && (op == OP_MV || op == OP_MVI);
    ar        = exec && (op == OP_ADD || op == OP_SUB);
    valid     = ar || (exec && t1);
    IRin      = fetch;
    Rin       = (mvs || (ar && t3)) ? rx : '0;
    Rout      = ((exec && t1 && op == OP_MV) || (ar && t2)) ? ry : ((ar && t1) ? rx : '0);
    Ain       = ar && t1;
    Gin       = ar && t2;
    AddSub    = ar && t2 && op[0];
    Gout      = ar && t3;
    DINout    = exec && t1 && op == OP_MVI;
    Done      = mvs || (ar && t3) || (exec && t1 && op[2]);
    StepClear = Clear || Done || (t0 && !Run) || (!t0 && !valid);
    Illegal   = ill && !Clear;
  end
  always_ff @(posedge Clock) begin
    if (Clear) begin
      ir   <= '0;
      busy <= 1'b0;
      ill  <= 1'b0;
    end else begin
      if (fetch) ir <= DIN;
      busy <= fetch || (busy && !StepClear);
      ill  <= ill || (exec && t1 && op[2]);
    end
  end
endmodule
